// File: rtl/lsu_bus_adapter.sv
// Load/store unit issuing one valid/ready bus transaction per legal core operation.
// Define LSU_TIMEOUT_EN to abort requests that see no response within TIMEOUT_CYCLES.
module lsu_bus_adapter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    available,
   input  logic                    is_write,
   input  logic                    is_unsigned,
   input  logic [1:0]              op,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   in,
   output logic [DATA_WIDTH-1:0]   out,
   output logic                    busy,
   output logic                    op_fault,
   output logic                    addr_fault,
   output logic                    access_fault,
   output logic                    bus_req_valid,
   input  logic                    bus_req_ready,
   output logic                    bus_req_write,
   output logic [ADDR_WIDTH-1:0]   bus_req_addr,
   output logic [DATA_WIDTH-1:0]   bus_req_wdata,
   output logic [DATA_WIDTH/8-1:0] bus_req_wstrb,
   input  logic                    bus_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata,
   input  logic                    bus_rsp_error
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int LW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("DATA_WIDTH must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t                   state_q, state_d;
   logic                     is_write_q, is_write_d;
   logic                     is_unsigned_q, is_unsigned_d;
   logic [1:0]               op_q, op_d;
   logic [LW-1:0]            off_q, off_d;
   logic [ADDR_WIDTH-1:LW]   addr_hi_q, addr_hi_d;
   logic [DATA_WIDTH-1:0]    in_q, in_d;
   logic [DATA_WIDTH-1:0]    out_q, out_d;
   logic                     op_fault_q, op_fault_d;
   logic                     addr_fault_q, addr_fault_d;
   logic                     acc_fault_q, acc_fault_d;

   logic                     op_invalid, misaligned, expired;
   logic [DATA_WIDTH-1:0]    wdata_rep, rsp_sh, word_ext, load_val;

   assign op_invalid = (op == 2'b11) && (DATA_WIDTH == 32);

   always_comb begin
      case (op)
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = |addr[1:0];
         2'b11:   misaligned = |addr[2:0];
         default: misaligned = 1'b0;
      endcase
   end

   // Each lane takes the byte of the narrow store value that lands on it.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] = (op_q == 2'b00) ? in_q[7:0] :
                                    (op_q == 2'b01) ? in_q[8*(gi%2) +: 8] :
                                    (op_q == 2'b10) ? in_q[8*(gi%4) +: 8] :
                                                      in_q[8*gi +: 8];
   end

   assign rsp_sh = bus_rsp_rdata >> {off_q, 3'b000};

   if (DATA_WIDTH == 64) begin : g_w64
      assign word_ext = {{(DATA_WIDTH-32){rsp_sh[31] & ~is_unsigned_q}}, rsp_sh[31:0]};
   end else begin : g_w32
      assign word_ext = rsp_sh;
   end

   always_comb begin
      case (op_q)
         2'b00:   load_val = {{(DATA_WIDTH-8){rsp_sh[7] & ~is_unsigned_q}}, rsp_sh[7:0]};
         2'b01:   load_val = {{(DATA_WIDTH-16){rsp_sh[15] & ~is_unsigned_q}}, rsp_sh[15:0]};
         2'b10:   load_val = word_ext;
         default: load_val = rsp_sh;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // REQ is only ever entered from IDLE, so clearing while idle clears on entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE)
         cnt_d = '0;
      else if (state_q == REQ || state_q == RSP)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         is_write_q    <= 1'b0;
         is_unsigned_q <= 1'b0;
         op_q          <= 2'b00;
         off_q         <= '0;
         addr_hi_q     <= '0;
         in_q          <= '0;
         out_q         <= '0;
         op_fault_q    <= 1'b0;
         addr_fault_q  <= 1'b0;
         acc_fault_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         is_write_q    <= is_write_d;
         is_unsigned_q <= is_unsigned_d;
         op_q          <= op_d;
         off_q         <= off_d;
         addr_hi_q     <= addr_hi_d;
         in_q          <= in_d;
         out_q         <= out_d;
         op_fault_q    <= op_fault_d;
         addr_fault_q  <= addr_fault_d;
         acc_fault_q   <= acc_fault_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      is_write_d    = is_write_q;
      is_unsigned_d = is_unsigned_q;
      op_d          = op_q;
      off_d         = off_q;
      addr_hi_d     = addr_hi_q;
      in_d          = in_q;
      out_d         = out_q;
      op_fault_d    = op_fault_q;
      addr_fault_d  = addr_fault_q;
      acc_fault_d   = acc_fault_q;
      case (state_q)
         IDLE: begin
            if (available) begin
               if (op_invalid) begin
                  op_fault_d = 1'b1;
                  state_d    = DONE;
               end else if (misaligned) begin
                  addr_fault_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  is_write_d    = is_write;
                  is_unsigned_d = is_unsigned;
                  op_d          = op;
                  off_d         = addr[LW-1:0];
                  addr_hi_d     = addr[ADDR_WIDTH-1:LW];
                  in_d          = in;
                  state_d       = REQ;
               end
            end
         end
         REQ: begin
            if (expired) begin
               acc_fault_d = 1'b1;
               state_d     = DONE;
            end else if (bus_req_ready) begin
               state_d = RSP;
            end
         end
         RSP: begin
            // A response in the expiry cycle takes priority over the timeout.
            if (bus_rsp_valid) begin
               acc_fault_d = bus_rsp_error;
               if (!is_write_q && !bus_rsp_error)
                  out_d = load_val;
               state_d = DONE;
            end else if (expired) begin
               acc_fault_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (!available) begin
               op_fault_d   = 1'b0;
               addr_fault_d = 1'b0;
               acc_fault_d  = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q == REQ) || (state_q == RSP);
      bus_req_valid = (state_q == REQ);
      bus_req_write = is_write_q;
      bus_req_addr  = {addr_hi_q, {LW{1'b0}}};
      bus_req_wdata = wdata_rep;
      case (op_q)
         2'b00:   bus_req_wstrb = NB'(1) << off_q;
         2'b01:   bus_req_wstrb = NB'(3) << off_q;
         2'b10:   bus_req_wstrb = NB'(15) << off_q;
         default: bus_req_wstrb = {NB{1'b1}};
      endcase
      if (!is_write_q)
         bus_req_wstrb = '0;
   end

   assign out          = out_q;
   assign op_fault     = op_fault_q;
   assign addr_fault   = addr_fault_q;
   assign access_fault = acc_fault_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: 32-bit and 64-bit instances driven in turn.
module tb_lsu_bus_adapter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        avail, wr, uns;
   logic [1:0]  op;
   logic [31:0] addr, din, dout;
   logic        busy, opf, adf, acf;
   logic        rv, rr, rw;
   logic [31:0] ra, wd;
   logic [3:0]  ws;
   logic        sv, se;
   logic [31:0] sd;

   // 64-bit instance
   logic        avail6, wr6, uns6;
   logic [1:0]  op6;
   logic [31:0] addr6;
   logic [63:0] din6, dout6;
   logic        busy6, opf6, adf6, acf6;
   logic        rv6, rr6, rw6;
   logic [31:0] ra6;
   logic [63:0] wd6;
   logic [7:0]  ws6;
   logic        sv6, se6;
   logic [63:0] sd6;

   int n_vec = 0;
   int n_err = 0;

   lsu_bus_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
      .clk(clk), .reset(reset), .available(avail), .is_write(wr), .is_unsigned(uns),
      .op(op), .addr(addr), .in(din), .out(dout), .busy(busy), .op_fault(opf),
      .addr_fault(adf), .access_fault(acf), .bus_req_valid(rv), .bus_req_ready(rr),
      .bus_req_write(rw), .bus_req_addr(ra), .bus_req_wdata(wd), .bus_req_wstrb(ws),
      .bus_rsp_valid(sv), .bus_rsp_rdata(sd), .bus_rsp_error(se)
   );

   lsu_bus_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(255)) dut64 (
      .clk(clk), .reset(reset), .available(avail6), .is_write(wr6), .is_unsigned(uns6),
      .op(op6), .addr(addr6), .in(din6), .out(dout6), .busy(busy6), .op_fault(opf6),
      .addr_fault(adf6), .access_fault(acf6), .bus_req_valid(rv6), .bus_req_ready(rr6),
      .bus_req_write(rw6), .bus_req_addr(ra6), .bus_req_wdata(wd6), .bus_req_wstrb(ws6),
      .bus_rsp_valid(sv6), .bus_rsp_rdata(sd6), .bus_rsp_error(se6)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      avail = 0; wr = 0; uns = 0; op = 0; addr = 0; din = 0; rr = 0; sv = 0; se = 0; sd = 0;
      avail6 = 0; wr6 = 0; uns6 = 0; op6 = 0; addr6 = 0; din6 = 0; rr6 = 0; sv6 = 0; se6 = 0; sd6 = 0;
      repeat (3) @(negedge clk);
      chk("rst_out", dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_faults", {opf, adf, acf}, 0);
      chk("rst_valid", rv, 0);
      chk("rst_out64", dout6, 0);
      chk("rst_valid64", rv6, 0);
      reset = 1'b0;
      @(negedge clk);

      // Signed byte load at lane 3, immediate ready and response
      avail = 1; wr = 0; uns = 0; op = 2'b00; addr = 32'h1003; rr = 1;
      @(negedge clk);
      chk("t1_busy_req", busy, 1);
      chk("t1_valid", rv, 1);
      chk("t1_write", rw, 0);
      chk("t1_addr", ra, 32'h1000);
      chk("t1_wstrb", ws, 4'b0000);
      @(negedge clk);
      chk("t1_valid_drop", rv, 0);
      chk("t1_busy_rsp", busy, 1);
      sv = 1; sd = 32'h80FF_FFFF;
      @(negedge clk);
      sv = 0;
      chk("t1_busy_low", busy, 0);
      chk("t1_out", dout, 32'hFFFF_FF80);
      chk("t1_faults", {opf, adf, acf}, 0);
      avail = 0;
      @(negedge clk);
      sv = 1; sd = 32'h0;
      @(negedge clk);
      sv = 0;
      chk("idle_rsp_ignored", dout, 32'hFFFF_FF80);
      chk("idle_busy", busy, 0);

      // Half store at lane 2 with ready held low; inputs change under it
      avail = 1; wr = 1; op = 2'b01; addr = 32'h2002; din = 32'h0000_ABCD; rr = 0;
      @(negedge clk);
      addr = 32'hFFFF_FFFF; din = 32'h1234_5678; op = 2'b00;
      chk("t2_valid", rv, 1);
      chk("t2_write", rw, 1);
      chk("t2_addr", ra, 32'h2000);
      chk("t2_wdata", wd, 32'hABCD_ABCD);
      chk("t2_wstrb", ws, 4'b1100);
      sv = 1; sd = 32'h5555_5555;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sv = 0;
         chk("t2_hold_valid", rv, 1);
         chk("t2_hold_addr", ra, 32'h2000);
         chk("t2_hold_wdata", wd, 32'hABCD_ABCD);
         chk("t2_hold_wstrb", ws, 4'b1100);
      end
      rr = 1;
      @(negedge clk);
      rr = 0;
      chk("t2_one_handshake", rv, 0);
      chk("t2_busy_rsp", busy, 1);
      sv = 1; sd = 32'h1234_5678;
      @(negedge clk);
      sv = 0;
      chk("t2_busy_low", busy, 0);
      chk("t2_store_out_kept", dout, 32'hFFFF_FF80);
      chk("t2_acc", acf, 0);
      avail = 0;
      @(negedge clk);

      // Misaligned word load
      avail = 1; wr = 0; op = 2'b10; addr = 32'h1002;
      @(negedge clk);
      chk("t3_addr_fault", adf, 1);
      chk("t3_op_fault", opf, 0);
      chk("t3_busy", busy, 0);
      chk("t3_valid", rv, 0);
      @(negedge clk);
      chk("t3_fault_hold", adf, 1);
      chk("t3_busy2", busy, 0);
      chk("t3_valid2", rv, 0);
      avail = 0;
      @(negedge clk);
      chk("t3_fault_clear", adf, 0);

      // Double on a 32-bit bus, also misaligned: only op_fault
      avail = 1; op = 2'b11; addr = 32'h1001;
      @(negedge clk);
      chk("t4_op_fault", opf, 1);
      chk("t4_addr_fault", adf, 0);
      chk("t4_valid", rv, 0);
      avail = 0;
      @(negedge clk);
      chk("t4_fault_clear", opf, 0);

      // Load answered with a bus error
      avail = 1; wr = 0; op = 2'b10; addr = 32'h3000; rr = 1;
      @(negedge clk);
      chk("t5_valid", rv, 1);
      @(negedge clk);
      sv = 1; se = 1; sd = 32'hDEAD_BEEF;
      @(negedge clk);
      sv = 0; se = 0;
      chk("t5_acc_fault", acf, 1);
      chk("t5_out_kept", dout, 32'hFFFF_FF80);
      chk("t5_busy", busy, 0);
      avail = 0;
      @(negedge clk);
      chk("t5_fault_clear", acf, 0);

      // Unsigned half load at lane 2
      avail = 1; op = 2'b01; uns = 1; addr = 32'h1002;
      @(negedge clk);
      @(negedge clk);
      sv = 1; sd = 32'h8001_1234;
      @(negedge clk);
      sv = 0;
      chk("t6_out", dout, 32'h0000_8001);
      avail = 0; uns = 0;
      @(negedge clk);

      // Byte store at lane 1
      avail = 1; wr = 1; op = 2'b00; addr = 32'h0000_0001; din = 32'h0000_005A; rr = 0;
      @(negedge clk);
      chk("t6b_wdata", wd, 32'h5A5A_5A5A);
      chk("t6b_wstrb", ws, 4'b0010);
      rr = 1;
      @(negedge clk);
      sv = 1;
      @(negedge clk);
      sv = 0;
      chk("t6b_busy", busy, 0);
      avail = 0;
      @(negedge clk);

      // Reset while a request is pending
      avail = 1; wr = 0; op = 2'b10; addr = 32'h0000_0010; rr = 0;
      @(negedge clk);
      chk("t7_valid", rv, 1);
      reset = 1;
      @(negedge clk);
      chk("t7_valid_drop", rv, 0);
      chk("t7_busy", busy, 0);
      chk("t7_out_reset", dout, 0);
      reset = 0; avail = 0;
      sv = 1; sd = 32'hFFFF_FFFF;
      @(negedge clk);
      sv = 0;
      @(negedge clk);
      chk("t7_late_rsp_ignored", dout, 0);
      chk("t7_idle_busy", busy, 0);

`ifdef LSU_TIMEOUT_EN
      // No response: abort four cycles after issue
      avail = 1; wr = 0; op = 2'b10; addr = 32'h0000_0020; rr = 1;
      @(negedge clk);
      chk("t8_busy_issue", busy, 1);
      repeat (3) @(negedge clk);
      chk("t8_busy_before", busy, 1);
      chk("t8_acc_before", acf, 0);
      @(negedge clk);
      chk("t8_busy_after", busy, 0);
      chk("t8_acc_after", acf, 1);
      avail = 0;
      @(negedge clk);
`endif

      // 64-bit: double load
      avail6 = 1; wr6 = 0; op6 = 2'b11; addr6 = 32'h8; rr6 = 1;
      @(negedge clk);
      chk("t9_valid", rv6, 1);
      chk("t9_addr", ra6, 32'h8);
      chk("t9_wstrb", ws6, 8'h00);
      @(negedge clk);
      sv6 = 1; sd6 = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      sv6 = 0;
      chk("t9_out", dout6, 64'h0123_4567_89AB_CDEF);
      chk("t9_busy", busy6, 0);
      chk("t9_faults", {opf6, adf6, acf6}, 0);
      avail6 = 0;
      @(negedge clk);

      // 64-bit: word store at lane 4
      avail6 = 1; wr6 = 1; op6 = 2'b10; addr6 = 32'h4; din6 = 64'hAAAA_AAAA_1122_3344; rr6 = 0;
      @(negedge clk);
      chk("t10_addr", ra6, 32'h0);
      chk("t10_wdata", wd6, 64'h1122_3344_1122_3344);
      chk("t10_wstrb", ws6, 8'hF0);
      rr6 = 1;
      @(negedge clk);
      sv6 = 1;
      @(negedge clk);
      sv6 = 0;
      avail6 = 0;
      @(negedge clk);

      // 64-bit: signed word load at lane 4
      avail6 = 1; wr6 = 0; uns6 = 0; op6 = 2'b10; addr6 = 32'h4; rr6 = 1;
      @(negedge clk);
      @(negedge clk);
      sv6 = 1; sd6 = 64'h8765_4321_0000_0000;
      @(negedge clk);
      sv6 = 0;
      chk("t11_out", dout6, 64'hFFFF_FFFF_8765_4321);
      avail6 = 0;
      @(negedge clk);

      // 64-bit: misaligned double
      avail6 = 1; op6 = 2'b11; addr6 = 32'hC;
      @(negedge clk);
      chk("t12_addr_fault", adf6, 1);
      chk("t12_op_fault", opf6, 0);
      chk("t12_valid", rv6, 0);
      avail6 = 0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
